// File: rtl/apb_i2c_fifo_if.sv
// Word push/pop bus between a producer/consumer (APB bridge or I2C core) and apb_i2c_fifo.
// Latency: none, this is wiring only.
// Backpressure: none on the bus itself; the FIFO status outputs (FULL/EMPTY) tell the master when to stop.
interface apb_i2c_fifo_if #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 4
);
   logic              WR_EN;
   logic [DWIDTH-1:0] WDATA;
   logic              RD_EN;
   logic              CLR_ERR;
   logic [DWIDTH-1:0] RDATA;
   logic              EMPTY;
   logic              FULL;
   logic              ALMOST_FULL;
   logic [AWIDTH:0]   COUNT;
   logic              OVERFLOW;
   logic              UNDERFLOW;

   // The side that pushes and pops words.
   modport master (
      output WR_EN, WDATA, RD_EN, CLR_ERR,
      input  RDATA, EMPTY, FULL, ALMOST_FULL, COUNT, OVERFLOW, UNDERFLOW
   );

   // The FIFO itself.
   modport slave (
      input  WR_EN, WDATA, RD_EN, CLR_ERR,
      output RDATA, EMPTY, FULL, ALMOST_FULL, COUNT, OVERFLOW, UNDERFLOW
   );
endinterface

// File: rtl/apb_i2c_fifo.sv
// Synchronous word FIFO between the APB bridge and the I2C core, with sticky overflow/underflow flags.
// Latency: push -> EMPTY low 1 cycle; registered RDATA 1 cycle after RD_EN (APB_I2C_FIFO_FWFT_EN: head word shown combinationally).
// Backpressure: pushes while FULL (without a same-cycle pop) and pops while EMPTY are dropped and flagged, never stalled.
module apb_i2c_fifo #(
   parameter int DWIDTH   = 32,
   parameter int AWIDTH   = 4,
   parameter int AF_LEVEL = 12
) (
   input  logic           PCLK,
   input  logic           PRESET,
   apb_i2c_fifo_if.slave  fifo
);

   localparam int              DEPTH    = 1 << AWIDTH;
   localparam logic [AWIDTH:0] FULL_CNT = DEPTH[AWIDTH:0];
   localparam logic [AWIDTH:0] AF_CNT   = AF_LEVEL[AWIDTH:0];

   logic [DWIDTH-1:0] mem [DEPTH];
   logic [AWIDTH-1:0] wptr;
   logic [AWIDTH-1:0] rptr;
   logic [AWIDTH:0]   count_r;
   logic [AWIDTH:0]   count_nxt;
   logic              empty_r;
   logic              full_r;
   logic              af_r;
   logic              ovf_r;
   logic              udf_r;
   logic              wr_ok;
   logic              rd_ok;

   // A pop frees a slot in the same cycle, so a full FIFO still takes a push alongside a pop.
   assign rd_ok = fifo.RD_EN & ~empty_r;
   assign wr_ok = fifo.WR_EN & (~full_r | rd_ok);

   // Occupancy after this cycle; simultaneous push and pop cancel out.
   always_comb begin
      count_nxt = count_r;
      if (wr_ok && !rd_ok)
         count_nxt = count_r + 1'b1;
      else if (rd_ok && !wr_ok)
         count_nxt = count_r - 1'b1;
   end

   // Storage array: written on every accepted push, deliberately not reset.
   always_ff @(posedge PCLK) begin
      if (!PRESET && wr_ok)
         mem[wptr] <= fifo.WDATA;
   end

   // Pointers, occupancy and status flags; flags are derived from count_nxt so they line up with COUNT.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         wptr    <= '0;
         rptr    <= '0;
         count_r <= '0;
         empty_r <= 1'b1;
         full_r  <= 1'b0;
         af_r    <= 1'b0;
      end else begin
         if (wr_ok)
            wptr <= wptr + 1'b1;
         if (rd_ok)
            rptr <= rptr + 1'b1;
         count_r <= count_nxt;
         empty_r <= (count_nxt == '0);
         full_r  <= (count_nxt == FULL_CNT);
         af_r    <= (count_nxt >= AF_CNT);
      end
   end

   // Sticky error flags: a new rejected access in the same cycle beats CLR_ERR.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         ovf_r <= 1'b0;
         udf_r <= 1'b0;
      end else begin
         if (fifo.WR_EN && !wr_ok)
            ovf_r <= 1'b1;
         else if (fifo.CLR_ERR)
            ovf_r <= 1'b0;

         if (fifo.RD_EN && !rd_ok)
            udf_r <= 1'b1;
         else if (fifo.CLR_ERR)
            udf_r <= 1'b0;
      end
   end

`ifdef APB_I2C_FIFO_FWFT_EN
   // Head word is presented as soon as it exists; RD_EN only acknowledges it.
   assign fifo.RDATA = empty_r ? '0 : mem[rptr];
`else
   logic [DWIDTH-1:0] rdata_r;

   // Registered read: the popped word appears the cycle after the accepted RD_EN and then holds.
   always_ff @(posedge PCLK) begin
      if (PRESET)
         rdata_r <= '0;
      else if (rd_ok)
         rdata_r <= mem[rptr];
   end

   assign fifo.RDATA = rdata_r;
`endif

   assign fifo.COUNT       = count_r;
   assign fifo.EMPTY       = empty_r;
   assign fifo.FULL        = full_r;
   assign fifo.ALMOST_FULL = af_r;
   assign fifo.OVERFLOW    = ovf_r;
   assign fifo.UNDERFLOW   = udf_r;

endmodule

// File: doc/apb_i2c_fifo.md
Name: apb_i2c_fifo

Overview:
- Synchronous FIFO that sits directly downstream of the APB bridge and buffers words for the I2C core.
- The TX instance takes the bridge's WR_ENA/WRITE_DATA_ON_TX on its write side; the I2C core pops it; its EMPTY drives the bridge's TX_EMPTY.
- The RX instance is the mirror image: the I2C core pushes, the bridge's RD_ENA pops, RDATA drives READ_DATA_ON_RX and EMPTY drives RX_EMPTY.
- Sticky overflow/underflow flags feed the bridge's ERROR input.

Parameters:
- DWIDTH, 32, data word width.
- AWIDTH, 4, address width; depth = 2**AWIDTH (16).
- AF_LEVEL, 12, ALMOST_FULL threshold in words (1..2**AWIDTH).

Ports:
- PCLK  in  1  clock; all logic on the rising edge.
- PRESET  in  1  reset, synchronous, active-high.
- WR_EN  in  1  push request (single-cycle strobe per word).
- WDATA  in  DWIDTH  push data, sampled when WR_EN=1.
- RD_EN  in  1  pop request.
- CLR_ERR  in  1  clears OVERFLOW/UNDERFLOW.
- RDATA  out  DWIDTH  pop data.
- EMPTY  out  1  COUNT==0.
- FULL  out  1  COUNT==2**AWIDTH.
- ALMOST_FULL  out  1  COUNT>=AF_LEVEL.
- COUNT  out  AWIDTH+1  words stored, 0..2**AWIDTH.
- OVERFLOW  out  1  sticky: a push was rejected.
- UNDERFLOW  out  1  sticky: a pop was rejected.

Behaviour:
- Reset (PRESET=1 at a PCLK edge): wptr=0, rptr=0, COUNT=0, EMPTY=1, FULL=0, ALMOST_FULL=0, OVERFLOW=0, UNDERFLOW=0, RDATA=0.
  - Memory array is not reset.
  - Reset overrides all same-cycle WR_EN/RD_EN/CLR_ERR.
  - Reset mid-transfer discards all stored words.
- Storage: 2**AWIDTH x DWIDTH register array. wptr and rptr are AWIDTH bits and wrap naturally from 2**AWIDTH-1 to 0.
- Push accept: wr_ok = WR_EN & (!FULL | rd_ok).
  - On wr_ok: mem[wptr] <= WDATA; wptr <= wptr+1.
- Pop accept: rd_ok = RD_EN & !EMPTY.
- COUNT update:
  - +1 on wr_ok & !rd_ok.
  - -1 on rd_ok & !wr_ok.
  - Unchanged otherwise, including simultaneous push and pop.
  - EMPTY, FULL and ALMOST_FULL are registered and derived from the next COUNT, so they are valid in the same cycle as COUNT.
- Simultaneous push and pop:
  - When FULL: both accepted, COUNT stays 2**AWIDTH, no OVERFLOW.
  - When EMPTY: push accepted, pop rejected and UNDERFLOW set; next COUNT=1. No write-through bypass.
- Error flags:
  - OVERFLOW <= 1 on WR_EN & !wr_ok.
  - UNDERFLOW <= 1 on RD_EN & !rd_ok.
  - CLR_ERR=1 clears both flags. A new error event in the same cycle wins (flag stays 1).
  - A rejected access never moves a pointer, COUNT or RDATA.
- Read data (default, registered):
  - On rd_ok, RDATA <= mem[rptr] and rptr <= rptr+1; the data is visible one cycle after the RD_EN edge.
  - RDATA holds its value when no pop is accepted, including a rejected pop.
- Latency:
  - Push to EMPTY deassert: 1 cycle.
  - Push to data poppable: next cycle.

Optional Feature:
- Macro: APB_I2C_FIFO_FWFT_EN (first-word-fall-through).
- Defined:
  - RDATA = mem[rptr] combinationally whenever EMPTY=0, and 0 when EMPTY=1.
  - RD_EN acknowledges the word already presented; RDATA changes to the next word in the cycle after the pop.
  - After a push into an empty FIFO, the word appears on RDATA in the cycle EMPTY falls.
- Undefined: registered read as described in Behaviour.
- All flags, COUNT and error behaviour are identical in both builds.

Test Plan:
- Reset then idle: PRESET=1 for 2 cycles -> COUNT=0, EMPTY=1, FULL=0, OVERFLOW=0, UNDERFLOW=0, RDATA=0.
- Push 0x11..0x1C (12 words) -> ALMOST_FULL rises on the cycle after the 12th push. Then push 0x1D..0x20 -> FULL=1, COUNT=16.
- Push 0xDEAD_BEEF while FULL -> OVERFLOW=1, COUNT=16. Pop 16 words -> 0x11..0x20 in order with no 0xDEADBEEF. Pulse CLR_ERR -> OVERFLOW=0.
- Pop while EMPTY -> UNDERFLOW=1, RDATA unchanged, COUNT=0. Push and pop in the same cycle while EMPTY -> COUNT=1, UNDERFLOW=1.
- FULL with WR_EN=RD_EN=1 for 40 cycles (data 0x100+i) -> COUNT stays 16, no OVERFLOW; pointers wrap twice; popped order is exactly FIFO.
- Push 0xA5A5_0001 into empty FIFO:
  - Default build: RD_EN one cycle later -> RDATA=0xA5A50001 on the following cycle.
  - APB_I2C_FIFO_FWFT_EN build: RDATA=0xA5A50001 as soon as EMPTY=0, before any RD_EN.
